// File: rtl/lane_compositor_pipe.sv
// lane_compositor_pipe: 3-stage pixel compositor for lane arrows, receptors, score bar and background.
// Stage 0 decodes boxes and issues the sprite ROM read, stage 1 waits on the ROM, stage 2 picks the colour.
module lane_compositor_pipe #(
    parameter int          NUM_LANES    = 4,
    parameter int          SPRITE_SIZE  = 32,
    parameter int          LANE_X0      = 100,
    parameter int          LANE_PITCH   = 50,
    parameter int          RECEPTOR_Y   = 400,
    parameter int          FLASH_FRAMES = 8,
    parameter logic [23:0] KEY_COLOR    = 24'hFF00FF,
    parameter int          SCORE_X0     = 560
) (
    input  logic                              Clk,
    input  logic                              Reset_n,
    input  logic                              pix_valid,
    input  logic [9:0]                        DrawX,
    input  logic [9:0]                        DrawY,
    input  logic                              frame_start,
    input  logic [NUM_LANES-1:0]              arrow_active,
    input  logic [10*NUM_LANES-1:0]           arrow_y,
    input  logic [NUM_LANES-1:0]              pressed,
    input  logic [NUM_LANES-1:0]              hit,
    output logic [2*$clog2(SPRITE_SIZE)+1:0]  rom_addr,
    input  logic [23:0]                       rom_data,
    output logic [7:0]                        VGA_R,
    output logic [7:0]                        VGA_G,
    output logic [7:0]                        VGA_B,
    output logic                              out_valid
);
    localparam int SW = $clog2(SPRITE_SIZE);
    localparam int FW = $clog2(FLASH_FRAMES + 1);
    localparam logic signed [10:0] SS = 11'(SPRITE_SIZE);
    localparam logic signed [10:0] RY = 11'(RECEPTOR_Y);

    logic [FW-1:0]      flash_q [NUM_LANES];
    logic [FW-1:0]      flash_d [NUM_LANES];
    logic               v0_q, v1_q, hit0_q, hit0_d, hit1_q, ov_q;
    logic [23:0]        fb0_q, fb0_d, fb1_q, rgb_q, rgb_d, rec_col;
    logic [2*SW+1:0]    addr_q, addr_d;
    logic signed [10:0] dx, dy, ry;
    logic               in_x, rec_hit;

    // Walk lanes high to low so the lowest matching lane overrides the rest.
    always_comb begin
        hit0_d  = 1'b0;
        addr_d  = addr_q;
        rec_hit = 1'b0;
        rec_col = '0;
        dx      = '0;
        dy      = '0;
        ry      = '0;
        in_x    = 1'b0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            dx   = $signed({1'b0, DrawX}) - $signed(11'(LANE_X0 + i * LANE_PITCH));
            dy   = $signed({1'b0, DrawY}) - $signed({1'b0, arrow_y[10*i +: 10]});
            ry   = $signed({1'b0, DrawY}) - RY;
            in_x = !dx[10] && dx < SS;
            if (in_x && arrow_active[i] && !dy[10] && dy < SS) begin
                hit0_d = 1'b1;
                addr_d = {2'(i), dy[SW-1:0], dx[SW-1:0]};
            end
            if (in_x && !ry[10] && ry < SS) begin
                rec_hit = 1'b1;
                rec_col = flash_q[i] != '0 ? 24'hFFFFFF : pressed[i] ? 24'h550000 : 24'h555555;
            end
        end
        fb0_d = rec_hit ? rec_col :
                DrawX >= 10'(SCORE_X0) ? {8'h7F - {1'b0, DrawY[9:3]}, 8'h00, 8'h05 + {1'b0, DrawY[9:3]}} :
                {8'h05, 8'h4B, 8'h7F - {1'b0, DrawX[9:3]}};
    end

    // A hit reloads even while flashing and beats a same-cycle frame decrement.
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++)
            flash_d[i] = hit[i] ? FW'(FLASH_FRAMES) :
                         (frame_start && flash_q[i] != '0) ? flash_q[i] - 1'b1 : flash_q[i];
    end

    // rom_data answers the address issued two edges earlier; key-coloured texels fall through.
    always_comb begin
        rgb_d = !v1_q ? 24'h0 : (hit1_q && rom_data != KEY_COLOR) ? rom_data : fb1_q;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            flash_q <= '{default: '0};
            v0_q    <= 1'b0;
            hit0_q  <= 1'b0;
            fb0_q   <= '0;
            addr_q  <= '0;
            v1_q    <= 1'b0;
            hit1_q  <= 1'b0;
            fb1_q   <= '0;
            rgb_q   <= '0;
            ov_q    <= 1'b0;
        end else begin
            flash_q <= flash_d;
            v0_q    <= pix_valid;
            hit0_q  <= hit0_d;
            fb0_q   <= fb0_d;
            addr_q  <= addr_d;
            v1_q    <= v0_q;
            hit1_q  <= hit0_q;
            fb1_q   <= fb0_q;
            rgb_q   <= rgb_d;
            ov_q    <= v1_q;
        end
    end

    assign rom_addr             = addr_q;
    assign {VGA_R, VGA_G, VGA_B} = rgb_q;
    assign out_valid            = ov_q;
endmodule

// File: tb/tb_lane_compositor_pipe.sv
// tb_lane_compositor_pipe: directed pixels with hand-computed colours checked by a queue-based monitor.
module tb_lane_compositor_pipe;
    logic        Clk = 1'b0, Reset_n = 1'b0, pix_valid = 1'b0, frame_start = 1'b0;
    logic [9:0]  DrawX = '0, DrawY = '0;
    logic [3:0]  arrow_active = '0, pressed = '0, hit = '0;
    logic [39:0] arrow_y = '0;
    logic [11:0] rom_addr, rom_addr_ovl, key_addr = 12'hFFF;
    logic [23:0] rom_data = '0;
    logic [7:0]  VGA_R, VGA_G, VGA_B, ovl_r, ovl_g, ovl_b;
    logic        out_valid, ovl_valid;
    int          cyc = 0, checks = 0, errors = 0;

    typedef struct {logic [23:0] rgb; int due;} exp_t;
    exp_t q[$];
    exp_t mon_e;

    lane_compositor_pipe dut (
        .Clk(Clk), .Reset_n(Reset_n), .pix_valid(pix_valid), .DrawX(DrawX), .DrawY(DrawY),
        .frame_start(frame_start), .arrow_active(arrow_active), .arrow_y(arrow_y),
        .pressed(pressed), .hit(hit), .rom_addr(rom_addr), .rom_data(rom_data),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .out_valid(out_valid)
    );

    lane_compositor_pipe #(.LANE_PITCH(20)) u_ovl (
        .Clk(Clk), .Reset_n(Reset_n), .pix_valid(pix_valid), .DrawX(DrawX), .DrawY(DrawY),
        .frame_start(frame_start), .arrow_active(arrow_active), .arrow_y(arrow_y),
        .pressed(pressed), .hit(hit), .rom_addr(rom_addr_ovl), .rom_data(rom_data),
        .VGA_R(ovl_r), .VGA_G(ovl_g), .VGA_B(ovl_b), .out_valid(ovl_valid)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(posedge Clk)
        rom_data <= (rom_addr == key_addr) ? 24'hFF00FF :
                    (rom_addr == 12'h545) ? 24'h123456 : {12'hC00, rom_addr};

    always @(negedge Clk) begin
        if (Reset_n) begin
            checks++;
            if (out_valid) begin
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out got=%h", {VGA_R, VGA_G, VGA_B});
                end else begin
                    mon_e = q.pop_front();
                    if ({VGA_R, VGA_G, VGA_B} !== mon_e.rgb || cyc != mon_e.due) begin
                        errors++;
                        $display("FAIL pixel got=%h at cyc %0d expected=%h at cyc %0d",
                                 {VGA_R, VGA_G, VGA_B}, cyc, mon_e.rgb, mon_e.due);
                    end
                end
            end else if ({VGA_R, VGA_G, VGA_B} !== 24'h0) begin
                errors++;
                $display("FAIL idle_rgb got=%h expected=000000", {VGA_R, VGA_G, VGA_B});
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                mon_e = q.pop_front();
                errors++;
                $display("FAIL missing_out expected=%h at cyc %0d", mon_e.rgb, mon_e.due);
            end
        end
    end

    task automatic chk(input string n, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", n, got, exp);
        end
    endtask

    task automatic pix(input int x, input int y, input logic [23:0] e);
        @(negedge Clk);
        DrawX = 10'(x);
        DrawY = 10'(y);
        pix_valid = 1'b1;
        q.push_back('{rgb: e, due: cyc + 3});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge Clk);
            pix_valid = 1'b0;
        end
    endtask

    task automatic pulse(input logic [3:0] h, input logic fs);
        @(negedge Clk);
        pix_valid   = 1'b0;
        hit         = h;
        frame_start = fs;
        @(negedge Clk);
        hit         = '0;
        frame_start = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        pix_valid = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_rgb", {VGA_R, VGA_G, VGA_B}, 24'h0);
        chk("rst_valid", {23'h0, out_valid}, 24'h0);
        chk("rst_addr", {12'h0, rom_addr}, 24'h0);
        @(negedge Clk);
        pix_valid = 1'b0;
        Reset_n = 1'b1;
        pix(0, 0, 24'h054B7F);
        idle(4);
        arrow_active = 4'b0010;
        arrow_y[19:10] = 10'd200;
        pix(155, 210, 24'h123456);
        @(posedge Clk);
        #1 chk("addr_lane1", {12'h0, rom_addr}, 24'h000545);
        idle(4);
        key_addr = 12'h545;
        arrow_y[19:10] = 10'd400;
        pix(155, 410, 24'h555555);
        idle(1);
        pressed = 4'b0010;
        pix(155, 410, 24'h550000);
        idle(4);
        pressed = '0;
        key_addr = 12'hFFF;
        pix(155, 410, 24'h123456);
        idle(4);
        arrow_active = '0;
        pulse(4'b0100, 1'b0);
        for (int k = 0; k <= 8; k++) begin
            pix(210, 410, k < 8 ? 24'hFFFFFF : 24'h555555);
            pulse(4'b0000, 1'b1);
        end
        pulse(4'b0100, 1'b1);
        pix(210, 410, 24'hFFFFFF);
        repeat (7) pulse(4'b0000, 1'b1);
        pix(210, 410, 24'hFFFFFF);
        pulse(4'b0000, 1'b1);
        pix(210, 410, 24'h555555);
        pulse(4'b0100, 1'b0);
        repeat (3) pulse(4'b0000, 1'b1);
        pulse(4'b0100, 1'b0);
        repeat (7) pulse(4'b0000, 1'b1);
        pix(210, 410, 24'hFFFFFF);
        pulse(4'b0000, 1'b1);
        pix(210, 410, 24'h555555);
        idle(1);
        pressed = 4'b0100;
        pix(210, 410, 24'h550000);
        idle(1);
        pressed = '0;
        arrow_active = 4'b0001;
        arrow_y[9:0] = 10'd200;
        pix(131, 210, 24'hC0015F);
        pix(132, 210, 24'h054B6F);
        pix(99, 210, 24'h054B73);
        pix(100, 199, 24'h054B73);
        pix(100, 200, 24'hC00000);
        pix(100, 231, 24'hC003E0);
        pix(100, 232, 24'h054B73);
        idle(1);
        arrow_y[9:0] = 10'd1000;
        pix(105, 0, 24'h054B72);
        pix(105, 1000, 24'hC00005);
        idle(1);
        arrow_active = 4'b0011;
        arrow_y[19:0] = {10'd200, 10'd200};
        pix(120, 210, 24'hC00154);
        @(posedge Clk);
        #1;
        chk("addr_prio", {12'h0, rom_addr}, 24'h000154);
        chk("addr_prio_ovl", {12'h0, rom_addr_ovl}, 24'h000154);
        pix(150, 210, 24'hC00540);
        idle(1);
        arrow_active = '0;
        pix(600, 80, 24'h75000F);
        pix(639, 0, 24'h7F0005);
        pix(559, 0, 24'h054B3A);
        pix(0, 0, 24'h054B7F);
        @(posedge Clk);
        #2;
        Reset_n = 1'b0;
        pix_valid = 1'b0;
        q.delete();
        #1;
        chk("midrst_rgb", {VGA_R, VGA_G, VGA_B}, 24'h0);
        chk("midrst_valid", {23'h0, out_valid}, 24'h0);
        chk("midrst_addr", {12'h0, rom_addr}, 24'h0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        pix(600, 80, 24'h75000F);
        pix(0, 0, 24'h054B7F);
        idle(6);
        chk("sb_empty", 24'(q.size()), 24'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lane_compositor_pipe.md
Name: lane_compositor_pipe

Overview:
- Pipelined, parametrised pixel compositor that replaces the single-cycle combinational colour mapper.
- Sits between the VGA controller (DrawX/DrawY) and the VGA DAC outputs.
- Composites N lanes of arrow sprites, per-lane receptors with hit-flash decay, a score bar and a gradient background.
- Sprite pixels come from an external synchronous sprite ROM with 1-cycle read latency. Outputs are registered with a fixed pipeline latency.

Parameters:
NUM_LANES, 4, number of note lanes (1..8)
SPRITE_SIZE, 32, sprite edge in pixels (power of two, 8..64)
LANE_X0, 100, left x of lane 0 sprite box
LANE_PITCH, 50, x spacing between lanes
RECEPTOR_Y, 400, top y of receptor row
FLASH_FRAMES, 8, frames a receptor stays flashed after a hit
KEY_COLOR, 24'hFF00FF, sprite transparency key {R,G,B}
SCORE_X0, 560, left x of score bar (bar spans SCORE_X0..639)

Ports:
Clk  in  1  pixel clock
Reset_n  in  1  asynchronous active-low reset
pix_valid  in  1  DrawX/DrawY valid (visible region)
DrawX  in  10  current pixel x
DrawY  in  10  current pixel y
frame_start  in  1  one-cycle pulse at start of each frame
arrow_active  in  NUM_LANES  lane has a live arrow
arrow_y  in  10*NUM_LANES  top y of each lane's arrow; lane i in bits [10i+9:10i]
pressed  in  NUM_LANES  lane key held
hit  in  NUM_LANES  one-cycle hit pulse per lane
rom_addr  out  2+2*log2(SPRITE_SIZE)  {sprite_id, sy, sx}
rom_data  in  24  ROM pixel {R,G,B}, valid 1 cycle after rom_addr
VGA_R, VGA_G, VGA_B  out  8 each  pixel colour
out_valid  out  1  pix_valid delayed to align with VGA_*

Behaviour:
- Reset (async, Reset_n=0):
  - VGA_R/G/B=0, out_valid=0, rom_addr=0.
  - All flash counters=0; all pipeline valid bits=0.
- Latency:
  - Exactly 3 cycles from DrawX/DrawY/pix_valid sample to VGA_*/out_valid.
  - Pipeline advances every cycle; there is no stall.
- Stage 0 (register):
  - Lane i box: x in [LANE_X0+i*LANE_PITCH, +SPRITE_SIZE) and y in [arrow_y[i], +SPRITE_SIZE). The left/top edge is inclusive; the right/bottom edge is exclusive.
  - Differences use 11-bit signed compares, so DrawX < box left never wraps into the box.
  - Arrow hit only if arrow_active[i]=1. The lowest lane index wins on overlap.
  - rom_addr = {i mod 4, sy, sx}, where sx/sy are the offsets into the box. If no arrow hit, rom_addr holds its previous value.
  - Fallback colour is computed in the same cycle, by priority:
    - receptor box (same x box, y in [RECEPTOR_Y, +SPRITE_SIZE)): FFFFFF if flash_cnt[i]>0; else 550000 if pressed[i]; else 555555.
    - score bar (DrawX>=SCORE_X0): R=7F-DrawY[9:3], G=00, B=05+DrawY[9:3].
    - background: R=05, G=4B, B=7F-DrawX[9:3] (8-bit, 1'b0-extended operands, no wrap possible).
- Stage 1: the ROM read is in flight; the arrow-hit flag, fallback colour and valid bit are delayed one stage.
- Stage 2 (output register):
  - If the arrow-hit flag is set and rom_data != KEY_COLOR, the output is rom_data.
  - Otherwise the output is the fallback colour. This makes a transparent sprite pixel show the receptor or background beneath it.
  - If the delayed pix_valid=0, VGA_*=0 and out_valid=0.
- Flash counters (one per lane, width clog2(FLASH_FRAMES+1)):
  - hit[i] loads FLASH_FRAMES.
  - Otherwise, frame_start decrements the counter if it is nonzero. It saturates at 0.
  - hit and frame_start in the same cycle: load wins.
  - hit while already flashing: reload to FLASH_FRAMES.
- Flash counters are sampled in stage 0, so a hit affects pixels sampled from the following cycle.
- Reset mid-frame clears the pipeline immediately. The first valid output after release appears 3 cycles after the first sampled pix_valid=1.

Test Plan:
- Reset then idle: Reset_n=0 with pix_valid=1 → VGA_*=0, out_valid=0. Release, DrawX=0, DrawY=0, no lanes active → 3 cycles later VGA=05,4B,7F.
- Arrow sprite: lane 1 active, arrow_y=200, DrawX=155, DrawY=210 → rom_addr={2'd1,5'd10,5'd5} next cycle. With rom_data=123456 returned → VGA=123456 exactly 3 cycles after sampling.
- Transparency: same pixel with rom_data=FF00FF and DrawY=RECEPTOR_Y+10=410 (arrow_y=400), lane not pressed → VGA=555555.
- Flash decay: hit[2] pulse, then 8 frame_start pulses. Receptor pixel of lane 2 reads FFFFFF until the 8th frame_start, then 555555. hit and frame_start in the same cycle → counter=8.
- Priority/boundary: lanes 0 and 1 both cover DrawX=LANE_X0+LANE_PITCH (LANE_PITCH<SPRITE_SIZE variant) → lane 0 sprite_id selected. DrawX=LANE_X0+SPRITE_SIZE (exclusive edge) → not in lane 0 box. arrow_y=1000 → no wrap hit at DrawY=0.
- Score bar and mid-stream reset: DrawX=600, DrawY=80 → VGA=75,00,0F. Assert Reset_n during streaming → outputs 0 at once, out_valid returns 3 cycles after release.
